// File: rtl/seq_booth_mul_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM encoding, Booth window codes and digit-count helper.
package seq_booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Window {b[2i+1], b[2i], b[2i-1]} codes
  localparam logic [2:0] WIN_ZERO_LO = 3'b000;
  localparam logic [2:0] WIN_P1_A    = 3'b001;
  localparam logic [2:0] WIN_P1_B    = 3'b010;
  localparam logic [2:0] WIN_P2      = 3'b011;
  localparam logic [2:0] WIN_M2      = 3'b100;
  localparam logic [2:0] WIN_M1_A    = 3'b101;
  localparam logic [2:0] WIN_M1_B    = 3'b110;
  localparam logic [2:0] WIN_ZERO_HI = 3'b111;

  // Radix-4 digits needed for an unsigned operand (two zero MSBs appended)
  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_digit_gen.sv
// Radix-4 Booth window decode: |digit|*a as a WIDTH+1-bit magnitude plus sign.
module booth_digit_gen
  import seq_booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       win,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH:0]   mag,
  output logic             neg
);

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (win)
      WIN_P1_A, WIN_P1_B: mag = {1'b0, a};
      WIN_P2:             mag = {a, 1'b0};
      WIN_M2: begin
        mag = {a, 1'b0};
        neg = 1'b1;
      end
      WIN_M1_A, WIN_M1_B: begin
        mag = {1'b0, a};
        neg = 1'b1;
      end
      WIN_ZERO_LO, WIN_ZERO_HI: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential unsigned multiplier, one radix-4 Booth digit per RUN cycle,
// valid/ready handshake on both sides with synchronous abort.
module seq_booth_mul
  import seq_booth_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int N  = booth_digits(WIDTH);
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * WIDTH + 2;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH+1:0] b_win;
  logic             b_prev;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    pp_q;
  logic             cin_q;
  logic [WIDTH:0]   mag;
  logic             neg;
  logic [AW-1:0]    pp_sh;
  logic             last;
  logic             unused_hi;

  booth_digit_gen #(.WIDTH(WIDTH)) u_digit (
    .win ({b_win[1:0], b_prev}),
    .a   (a_q),
    .mag (mag),
    .neg (neg)
  );

  assign pp_sh = AW'(mag) << {cnt, 1'b0};
  // Decode is registered; the add trails it by one cycle, hence N+1 RUN cycles.
  assign last  = (cnt == CW'(N));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE: if (abort || out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_win  <= '0;
      b_prev <= 1'b0;
      acc    <= '0;
      pp_q   <= '0;
      cin_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_q    <= a;
          b_win  <= {2'b00, b};
          b_prev <= 1'b0;
          cnt    <= '0;
          acc    <= '0;
          pp_q   <= '0;
          cin_q  <= 1'b0;
        end
        RUN: if (abort) begin
          cnt   <= '0;
          acc   <= '0;
          pp_q  <= '0;
          cin_q <= 1'b0;
        end else begin
          // Negative digits: one's complement here, +1 via carry-in at the add
          acc    <= acc + pp_q + AW'(cin_q);
          pp_q   <= neg ? ~pp_sh : pp_sh;
          cin_q  <= neg;
          b_prev <= b_win[1];
          b_win  <= b_win >> 2;
          cnt    <= cnt + CW'(1);
        end
        DONE: if (abort) begin
          cnt <= '0;
          acc <= '0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign prod      = acc[2*WIDTH-1:0];
  assign unused_hi = ^acc[AW-1:2*WIDTH];

endmodule

// File: tb/tb_seq_booth_mul.sv
// Bench for seq_booth_mul: timeline model of a*b with N+1-edge latency,
// directed literal cases, abort/backpressure/reset, then a random sweep.
module tb_seq_booth_mul;

  localparam int W = 8;
  localparam int N = W / 2 + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, abort, out_ready;
  logic [W-1:0]   a, b;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] prod;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // behavioural model: idle / counting down / holding a product
  bit             m_busy = 1'b0;
  bit             m_done = 1'b0;
  int             m_left = 0;
  logic [2*W-1:0] m_exp  = '0;
  int             n_acc  = 0;
  int             n_ret  = 0;

  seq_booth_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
    end else if (m_done) begin
      if (abort || out_ready) begin
        m_done <= 1'b0;
        if (!abort) n_ret <= n_ret + 1;
      end
    end else if (m_busy) begin
      if (abort) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
      end else m_left <= m_left - 1;
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_left <= N + 1;
      m_exp  <= (2*W)'(a) * (2*W)'(b);
      n_acc  <= n_acc + 1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_in_ready", in_ready, !(m_busy || m_done));
      chk("mon_out_valid", out_valid, m_done);
      chk("mon_busy", busy, m_busy || m_done);
      if (m_done) chk("mon_prod", prod, m_exp);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", in_ready, 1);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] lit, input logic rdy);
    int edges;
    wait_idle();
    in_valid = 1'b1; a = av; b = bv; out_ready = rdy;
    @(posedge clk); #1;
    chk("model_literal", m_exp, lit);
    @(negedge clk);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latency_edges", edges, N + 1);
    chk("prod_literal", prod, lit);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prod", prod, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    run_op(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    @(negedge clk);
    chk("ff_in_ready_after", in_ready, 1);
    run_op(8'h80, 8'h02, 16'h0100, 1'b1);
    run_op(8'h00, 8'hA5, 16'h0000, 1'b1);
    run_op(8'h37, 8'h00, 16'h0000, 1'b1);
    run_op(8'hFF, 8'h01, 16'h00FF, 1'b1);
    run_op(8'hAA, 8'h55, 16'h3872, 1'b1);

    // backpressure with a new pair held on in_valid
    run_op(8'h0F, 8'h11, 16'h00FF, 1'b0);
    in_valid = 1'b1; a = 8'h12; b = 8'h34;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_prod", prod, 16'h00FF);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_retire_in_ready", in_ready, 1);
    chk("bp_retire_out_valid", out_valid, 0);
    @(negedge clk);
    chk("bp_next_accepted", busy, 1);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_next_prod", prod, 16'h03A8);

    // abort on RUN cycle with cnt=2
    wait_idle();
    in_valid = 1'b1; a = 8'hAB; b = 8'hCD;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    run_op(8'h03, 8'h05, 16'h000F, 1'b1);

    // asynchronous reset mid-RUN
    wait_idle();
    in_valid = 1'b1; a = 8'h5A; b = 8'hC3;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_prod", prod, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // random sweep, model compares every cycle
    cyc = 0;
    begin
      int target;
      target = n_acc + 1000;
      while (n_acc < target && cyc < 40000) begin
        @(negedge clk);
        cyc++;
        in_valid  = ($urandom % 4) != 0;
        a         = ($urandom % 8 == 0) ? '1 : W'($urandom);
        b         = ($urandom % 8 == 0) ? '0 : W'($urandom);
        out_ready = ($urandom % 3) != 0;
        abort     = ($urandom % 40) == 0;
      end
      chk("sweep_complete", n_acc >= target, 1);
    end
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("sweep_idle_end", in_ready, 1);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
